// File: rtl/shift_queue_ctrl_pkg.sv
// rtl/shift_queue_ctrl_pkg.sv - shared shift-queue select encodings and width helpers
package shift_queue_ctrl_pkg;

    typedef enum logic [1:0] {
        SEL_ZERO  = 2'b00,
        SEL_DIN   = 2'b01,
        SEL_SHIFT = 2'b10
    } entry_sel_e;

    function automatic int count_width(input int n_entries);
        return $clog2(n_entries) + 1;
    endfunction

endpackage

// File: rtl/sq_count_reg.sv
// rtl/sq_count_reg.sv - occupancy up/down counter with clear, async active-low reset
module sq_count_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !dec) begin
            count <= count + 1'b1;
        end else if (dec && !inc) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/shift_queue_ctrl.sv
// rtl/shift_queue_ctrl.sv - shift-queue controller: handshakes, per-entry write/select, occupancy
module shift_queue_ctrl
    import shift_queue_ctrl_pkg::*;
#(
    parameter int N_ENTRIES   = 8,
    parameter int ENTRY_WIDTH = 81
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  valid_i,
    output logic                                  ready_o,
    input  logic                                  ready_i,
    output logic                                  valid_o,
    input  logic                                  flush_i,
    output logic [N_ENTRIES-1:0]                  entry_we_o,
    output logic [2*N_ENTRIES-1:0]                entry_sel_o,
    output logic [$clog2(N_ENTRIES)-1:0]          out_sel_o,
    output logic [count_width(N_ENTRIES)-1:0]     count_o,
    output logic                                  full_o,
    output logic                                  empty_o
);

    localparam int CW = count_width(N_ENTRIES);
    localparam int SW = $clog2(N_ENTRIES);

    if (N_ENTRIES < 2 || (N_ENTRIES & (N_ENTRIES - 1)) != 0 || ENTRY_WIDTH < 1) begin : g_bad_cfg
        $error("shift_queue_ctrl: N_ENTRIES must be a power of two >= 2 and ENTRY_WIDTH >= 1");
    end

    logic [CW-1:0] count;
    logic          enq;
    logic          deq;

    sq_count_reg #(.W(CW)) u_count (
        .clk   (clk),
        .rst   (rst),
        .inc   (enq),
        .dec   (deq),
        .clr   (flush_i),
        .count (count)
    );

    // Handshakes depend only on occupancy, so ready_o never waits on ready_i.
    always_comb begin
        full_o    = (count == CW'(N_ENTRIES));
        empty_o   = (count == '0);
        ready_o   = !full_o;
        valid_o   = !empty_o;
        enq       = valid_i && ready_o && !flush_i;
        deq       = valid_o && ready_i && !flush_i;
        count_o   = count;
        out_sel_o = empty_o ? '0 : SW'(count - 1'b1);
    end

    // Newest lives at entry 0; an enqueue shifts the occupied range up by one.
    always_comb begin
        entry_we_o  = '0;
        entry_sel_o = '0;
        if (rst) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                if (flush_i) begin
                    entry_we_o[i]        = 1'b1;
                    entry_sel_o[2*i +: 2] = SEL_ZERO;
                end else if (enq) begin
                    if (i == 0) begin
                        entry_we_o[i]        = 1'b1;
                        entry_sel_o[2*i +: 2] = SEL_DIN;
                    end else if (CW'(i) < count) begin
                        entry_we_o[i]        = 1'b1;
                        entry_sel_o[2*i +: 2] = SEL_SHIFT;
                    end else if (CW'(i) == count) begin
                        // With a concurrent dequeue the vacated top slot is zeroed instead.
                        entry_we_o[i]        = 1'b1;
                        entry_sel_o[2*i +: 2] = deq ? SEL_ZERO : SEL_SHIFT;
                    end
                end else if (deq && (CW'(i) == count - 1'b1)) begin
                    entry_we_o[i]        = 1'b1;
                    entry_sel_o[2*i +: 2] = SEL_ZERO;
                end
            end
        end
    end

endmodule
